// File: rtl/ika3012_serial_rx.sv
// ika3012_serial_rx: receive side of the YM3012-style serial DAC link.
// Deserialises LSB-first 16-bit frames on i_SO and decodes the 10-bit
// mantissa / 3-bit exponent into 16-bit signed samples.
// SH1 falling edges latch the left sample and SH2 falling edges latch the right.
// Optional framing check: define IKA3012_FRMCHK_EN to enable the bit counter and o_FRMERR.
module ika3012_serial_rx (
  input  logic        i_EMUCLK,
  input  logic        i_RST,
  input  logic        i_CEN_n,
  input  logic        i_SO,
  input  logic        i_SH1,
  input  logic        i_SH2,
  output logic [15:0] o_L,
  output logic [15:0] o_R,
  output logic        o_L_VALID,
  output logic        o_R_VALID,
  output logic        o_FRMERR
);

  logic        en;
  logic        fall1;
  logic        fall2;
  logic [15:0] sr_q,  sr_d;
  logic        sh1_q, sh1_d;
  logic        sh2_q, sh2_d;
  logic [15:0] l_q,   l_d;
  logic [15:0] r_q,   r_d;
  logic        lv_q,  lv_d;
  logic        rv_q,  rv_d;
  logic [15:0] dec;
  logic [15:0] mant_ext;
  logic [2:0]  shamt;

  assign en    = ~i_CEN_n;
  assign fall1 = en & sh1_q & ~i_SH1;
  assign fall2 = en & sh2_q & ~i_SH2;

  // Decode the frame word held before this cycle's shift: sign-extended mantissa scaled by 2^(E-1)
  always_comb begin
    mant_ext = {{6{sr_q[12]}}, sr_q[12:3]};
    shamt    = sr_q[15:13] - 3'd1;
    dec      = '0;
    if (sr_q[15:13] != 3'd0) begin
      dec = mant_ext << shamt;
    end
  end

  // Next-state logic for the shifter, strobe history, sample latches and VALID pulses
  always_comb begin
    sr_d  = sr_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    l_d   = l_q;
    r_d   = r_q;
    lv_d  = 1'b0;
    rv_d  = 1'b0;
    if (en) begin
      sr_d  = {i_SO, sr_q[15:1]};
      sh1_d = i_SH1;
      sh2_d = i_SH2;
    end
    if (fall1) begin
      l_d  = dec;
      lv_d = 1'b1;
    end
    if (fall2) begin
      r_d  = dec;
      rv_d = 1'b1;
    end
  end

  // Register update with synchronous active-high reset
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      sr_q  <= '0;
      sh1_q <= 1'b0;
      sh2_q <= 1'b0;
      l_q   <= '0;
      r_q   <= '0;
      lv_q  <= 1'b0;
      rv_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      l_q   <= l_d;
      r_q   <= r_d;
      lv_q  <= lv_d;
      rv_q  <= rv_d;
    end
  end

  assign o_L       = l_q;
  assign o_R       = r_q;
  assign o_L_VALID = lv_q;
  assign o_R_VALID = rv_q;

`ifdef IKA3012_FRMCHK_EN
  logic [4:0] bitcnt_q, bitcnt_d;
  logic       frmerr_q, frmerr_d;

  // Count bits since the last accepted edge; any edge checks for exactly 16, once per cycle
  always_comb begin
    bitcnt_d = bitcnt_q;
    frmerr_d = frmerr_q;
    if (fall1 | fall2) begin
      if (bitcnt_q != 5'd16) begin
        frmerr_d = 1'b1;
      end
      bitcnt_d = 5'd1;
    end else if (en && bitcnt_q != 5'd31) begin
      bitcnt_d = bitcnt_q + 5'd1;
    end
  end

  // Bit counter and sticky error flag
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      bitcnt_q <= '0;
      frmerr_q <= 1'b0;
    end else begin
      bitcnt_q <= bitcnt_d;
      frmerr_q <= frmerr_d;
    end
  end

  assign o_FRMERR = frmerr_q;
`else
  assign o_FRMERR = 1'b0;
`endif

endmodule

// File: tb/tb_ika3012_serial_rx.sv
// Directed bench for ika3012_serial_rx with hand-computed decode results.
module tb_ika3012_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen_n;
  logic        so;
  logic        sh1;
  logic        sh2;
  logic [15:0] o_l;
  logic [15:0] o_r;
  logic        o_lv;
  logic        o_rv;
  logic        o_err;

  int checks = 0;
  int errors = 0;

`ifdef IKA3012_FRMCHK_EN
  localparam logic FRMCHK = 1'b1;
`else
  localparam logic FRMCHK = 1'b0;
`endif

  ika3012_serial_rx dut (
    .i_EMUCLK (clk),
    .i_RST    (rst),
    .i_CEN_n  (cen_n),
    .i_SO     (so),
    .i_SH1    (sh1),
    .i_SH2    (sh2),
    .o_L      (o_l),
    .o_R      (o_r),
    .o_L_VALID(o_lv),
    .o_R_VALID(o_rv),
    .o_FRMERR (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One enabled link cycle; returns 1 ns after the clock edge
  task automatic bit_cyc(input logic b, input logic s1, input logic s2);
    cen_n = 1'b0;
    so    = b;
    sh1   = s1;
    sh2   = s2;
    @(posedge clk);
    #1;
  endtask

  // One disabled cycle; strobes are deliberately toggled to show they are ignored
  task automatic idle_cyc();
    cen_n = 1'b1;
    so    = ~so;
    sh1   = ~sh1;
    sh2   = ~sh2;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet();
    check("l_valid_quiet", {15'd0, o_lv}, 16'h0000);
    check("r_valid_quiet", {15'd0, o_rv}, 16'h0000);
  endtask

  // Send bits first_bit..nbits-1 of w with the strobes high on the last bit,
  // then the edge cycle, which carries bit 0 of the following word nxt.
  task automatic run_frame(input logic [15:0] w, input logic [15:0] nxt, input int first_bit,
                           input int nbits, input logic s1, input logic s2, input int stall);
    for (int i = first_bit; i < nbits; i++) begin
      for (int k = 0; k < stall; k++) begin
        idle_cyc();
        chk_quiet();
      end
      bit_cyc(w[i], (i == nbits - 1) ? s1 : 1'b0, (i == nbits - 1) ? s2 : 1'b0);
      chk_quiet();
    end
    for (int k = 0; k < stall; k++) begin
      idle_cyc();
      chk_quiet();
    end
    bit_cyc(nxt[0], 1'b0, 1'b0);
  endtask

  task automatic chk_edge(input string tag, input logic [15:0] el, input logic elv,
                          input logic [15:0] er, input logic erv, input logic eerr);
    check({tag, "_L"},      o_l, el);
    check({tag, "_LVALID"}, {15'd0, o_lv}, {15'd0, elv});
    check({tag, "_R"},      o_r, er);
    check({tag, "_RVALID"}, {15'd0, o_rv}, {15'd0, erv});
    check({tag, "_FRMERR"}, {15'd0, o_err}, {15'd0, eerr});
  endtask

  initial begin
    rst   = 1'b1;
    cen_n = 1'b0;
    so    = 1'b0;
    sh1   = 1'b0;
    sh2   = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk_edge("reset", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    // Positive mantissa on SH1: M=0x100, E=3 -> 0x0400
    run_frame(16'h6800, 16'hF000, 0, 16, 1'b1, 1'b0, 0);
    chk_edge("pos", 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b0);

    // Most negative on SH2: M=-512, E=7 -> 0x8000
    run_frame(16'hF000, 16'hEFF8, 1, 16, 1'b0, 1'b1, 0);
    chk_edge("neg", 16'h0400, 1'b0, 16'h8000, 1'b1, 1'b0);

    // Most positive on SH2: M=511, E=7 -> 0x7FC0
    run_frame(16'hEFF8, 16'h0FF8, 1, 16, 1'b0, 1'b1, 0);
    chk_edge("max", 16'h0400, 1'b0, 16'h7FC0, 1'b1, 1'b0);

    // E=0 with both strobes together -> both channels 0, both pulses
    run_frame(16'h0FF8, 16'h6800, 1, 16, 1'b1, 1'b1, 0);
    chk_edge("both", 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-to-back frames with enable one cycle in four
    run_frame(16'h6800, 16'hF000, 1, 16, 1'b1, 1'b0, 3);
    chk_edge("stall1", 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b0);
    run_frame(16'hF000, 16'hEFF8, 1, 16, 1'b0, 1'b1, 3);
    chk_edge("stall2", 16'h0400, 1'b0, 16'h8000, 1'b1, 1'b0);
    run_frame(16'hEFF8, 16'h6800, 1, 16, 1'b1, 1'b0, 3);
    chk_edge("stall3", 16'h7FC0, 1'b1, 16'h8000, 1'b0, 1'b0);

    // Short frame: SH1 falls after 12 bits
    run_frame(16'h6800, 16'h6800, 1, 12, 1'b1, 1'b0, 0);
    check("short_LVALID", {15'd0, o_lv}, 16'h0001);
    check("short_FRMERR", {15'd0, o_err}, {15'd0, FRMCHK});
    run_frame(16'h6800, 16'h0000, 1, 16, 1'b1, 1'b0, 0);
    chk_edge("after_short", 16'h0400, 1'b1, 16'h8000, 1'b0, FRMCHK);

    // Reset after 8 bits of a frame, then a clean frame
    for (int i = 1; i < 8; i++) begin
      bit_cyc(1'b1, 1'b0, 1'b0);
    end
    rst = 1'b1;
    bit_cyc(1'b1, 1'b0, 1'b0);
    chk_edge("midreset", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    run_frame(16'h6800, 16'h0000, 0, 16, 1'b1, 1'b0, 0);
    chk_edge("post_reset", 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b0);
    bit_cyc(1'b0, 1'b0, 1'b0);
    chk_quiet();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
